// File: rtl/rob_retire_ctrl_if.sv
// Reorder-buffer retrieve bus: head window presented by the buffer and the
// pop request returned by the commit sequencer.
interface rob_retire_ctrl_if #(
  parameter int unsigned EXT_COUNT    = 4,
  parameter int unsigned EXTCOUNTLOG2 = $clog2(EXT_COUNT)
);
  logic [EXT_COUNT-1:0]         slot_valid;
  logic [EXT_COUNT-1:0]         slot_kill;
  logic [EXT_COUNT-1:0][4:0]    slot_dest_reg;
  logic [EXT_COUNT-1:0]         slot_dest_valid;
  logic [EXT_COUNT-1:0][31:0]   slot_result;
  logic [EXT_COUNT-1:0]         slot_is_store;
  logic                         empty;
  logic                         consume;
  logic [EXTCOUNTLOG2-1:0]      consume_count;

  // Buffer side: presents the head window, receives the pop.
  modport master (
    output slot_valid, slot_kill, slot_dest_reg, slot_dest_valid,
           slot_result, slot_is_store, empty,
    input  consume, consume_count
  );

  // Commit sequencer side.
  modport slave (
    input  slot_valid, slot_kill, slot_dest_reg, slot_dest_valid,
           slot_result, slot_is_store, empty,
    output consume, consume_count
  );
endinterface

// File: rtl/rob_retire_ctrl.sv
// Commit sequencer: retires the longest in-order retirable prefix of the
// reorder-buffer head window, issues registered register-file writes,
// commits stores one at a time via req/ack, and supports drain-and-halt.
module rob_retire_ctrl #(
  parameter int unsigned EXT_COUNT    = 4,
  parameter int unsigned RF_PORTS     = 2,
  parameter int unsigned EXTCOUNTLOG2 = $clog2(EXT_COUNT)
) (
  input  logic                        clock,
  input  logic                        reset,
  rob_retire_ctrl_if.slave            rob,
  output logic [RF_PORTS-1:0]         rf_we,
  output logic [RF_PORTS-1:0][4:0]    rf_waddr,
  output logic [RF_PORTS-1:0][31:0]   rf_wdata,
  output logic                        st_commit_req,
  input  logic                        st_commit_ack,
  input  logic                        halt_req,
  output logic                        halted,
  output logic [31:0]                 retired_count
);

  typedef enum logic [1:0] {RUN, ST_WAIT, HALT} state_t;

  state_t state;

  int unsigned                 grp_n;
  int unsigned                 grp_writes;
  int unsigned                 grp_live;
  logic                        grp_stop;
  logic [RF_PORTS-1:0]         grp_we;
  logic [RF_PORTS-1:0][4:0]    grp_waddr;
  logic [RF_PORTS-1:0][31:0]   grp_wdata;

  logic run_retire;
  logic run_store;
  logic run_halt;
  logic wait_ack;

  // Scan the head window for the retirable prefix and map its
  // register writers onto write ports in age order.
  always_comb begin
    grp_n      = 0;
    grp_writes = 0;
    grp_live   = 0;
    grp_stop   = 1'b0;
    grp_we     = '0;
    grp_waddr  = '0;
    grp_wdata  = '0;
    for (int unsigned i = 0; i < EXT_COUNT; i++) begin
      if (!grp_stop) begin
        if (!rob.slot_valid[i] ||
            (!rob.slot_kill[i] && rob.slot_is_store[i]) ||
            (!rob.slot_kill[i] && rob.slot_dest_valid[i] && grp_writes == RF_PORTS)) begin
          grp_stop = 1'b1;
        end else begin
          grp_n = grp_n + 1;
          if (!rob.slot_kill[i]) begin
            grp_live = grp_live + 1;
            if (rob.slot_dest_valid[i]) begin
              for (int unsigned k = 0; k < RF_PORTS; k++) begin
                if (k == grp_writes) begin
                  grp_we[k]    = 1'b1;
                  grp_waddr[k] = rob.slot_dest_reg[i];
                  grp_wdata[k] = rob.slot_result[i];
                end
              end
              grp_writes = grp_writes + 1;
            end
          end
        end
      end
    end
  end

  // Per-state decisions; halt_req in RUN pre-empts both retirement and store start.
  always_comb begin
    run_halt   = (state == RUN) && halt_req;
    run_retire = (state == RUN) && !halt_req && !rob.empty && (grp_n != 0);
    run_store  = (state == RUN) && !halt_req && !rob.empty && (grp_n == 0) &&
                 rob.slot_valid[0] && !rob.slot_kill[0] && rob.slot_is_store[0];
    wait_ack   = (state == ST_WAIT) && st_commit_ack;
  end

  // Buffer pop: a whole group in RUN, or the single store on its ack.
  always_comb begin
    rob.consume       = 1'b0;
    rob.consume_count = '0;
    if (!reset) begin
      if (run_retire) begin
        rob.consume       = 1'b1;
        rob.consume_count = EXTCOUNTLOG2'(grp_n - 1);
      end else if (wait_ack) begin
        rob.consume       = 1'b1;
        rob.consume_count = '0;
      end
    end
  end

  // State machine with registered write ports, store request, halt flag and counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= RUN;
      rf_we         <= '0;
      rf_waddr      <= '0;
      rf_wdata      <= '0;
      st_commit_req <= 1'b0;
      halted        <= 1'b0;
      retired_count <= '0;
    end else begin
      rf_we <= '0;
      case (state)
        RUN: begin
          if (run_halt) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (run_retire) begin
            rf_we         <= grp_we;
            retired_count <= retired_count + 32'(grp_live);
            for (int unsigned k = 0; k < RF_PORTS; k++) begin
              if (grp_we[k]) begin
                rf_waddr[k] <= grp_waddr[k];
                rf_wdata[k] <= grp_wdata[k];
              end
            end
          end else if (run_store) begin
            state         <= ST_WAIT;
            st_commit_req <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (st_commit_ack) begin
            st_commit_req <= 1'b0;
            retired_count <= retired_count + 32'd1;
            state         <= halt_req ? HALT : RUN;
            halted        <= halt_req;
          end
        end
        HALT: begin
          if (!halt_req) begin
            state  <= RUN;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rob_retire_ctrl.sv
// Directed bench for rob_retire_ctrl (EXT_COUNT=4, RF_PORTS=2).
module tb_rob_retire_ctrl;

  logic              clock;
  logic              reset;
  logic [1:0]        rf_we;
  logic [1:0][4:0]   rf_waddr;
  logic [1:0][31:0]  rf_wdata;
  logic              st_commit_req;
  logic              st_commit_ack;
  logic              halt_req;
  logic              halted;
  logic [31:0]       retired_count;

  int unsigned errors = 0;
  int unsigned checks = 0;

  rob_retire_ctrl_if #(.EXT_COUNT(4)) rob ();

  rob_retire_ctrl #(.EXT_COUNT(4), .RF_PORTS(2)) dut (
    .clock         (clock),
    .reset         (reset),
    .rob           (rob),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .st_commit_req (st_commit_req),
    .st_commit_ack (st_commit_ack),
    .halt_req      (halt_req),
    .halted        (halted),
    .retired_count (retired_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic win(input logic [3:0] v, input logic [3:0] k,
                     input logic [3:0] dv, input logic [3:0] st);
    rob.slot_valid      = v;
    rob.slot_kill       = k;
    rob.slot_dest_valid = dv;
    rob.slot_is_store   = st;
  endtask

  initial begin
    reset         = 1'b1;
    st_commit_ack = 1'b0;
    halt_req      = 1'b0;
    rob.empty     = 1'b1;
    win(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      rob.slot_dest_reg[i] = 5'(i + 1);
      rob.slot_result[i]   = 32'hC0DE_0000 + 32'(i);
    end
    tick();
    tick();
    check("rst_consume", {31'd0, rob.consume}, 32'd0);
    check("rst_rf_we", {30'd0, rf_we}, 32'd0);
    check("rst_waddr", {22'd0, rf_waddr}, 32'd0);
    check("rst_wdata0", rf_wdata[0], 32'd0);
    check("rst_req", {31'd0, st_commit_req}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_retired", retired_count, 32'd0);
    reset = 1'b0;

    // Full window, all writers: limited to two by the write ports.
    win(4'b1111, 4'b0000, 4'b1111, 4'b0000);
    rob.empty = 1'b0;
    #2;
    check("t1_consume", {31'd0, rob.consume}, 32'd1);
    check("t1_count", {30'd0, rob.consume_count}, 32'd1);
    tick();
    check("t1_we", {30'd0, rf_we}, 32'd3);
    check("t1_waddr0", {27'd0, rf_waddr[0]}, 32'd1);
    check("t1_wdata0", rf_wdata[0], 32'hC0DE_0000);
    check("t1_waddr1", {27'd0, rf_waddr[1]}, 32'd2);
    check("t1_wdata1", rf_wdata[1], 32'hC0DE_0001);
    check("t1_retired", retired_count, 32'd2);

    // Empty buffer suppresses consume despite valid slots.
    rob.empty = 1'b1;
    #2;
    check("empty_consume", {31'd0, rob.consume}, 32'd0);
    tick();
    check("empty_we", {30'd0, rf_we}, 32'd0);
    check("empty_retired", retired_count, 32'd2);

    // Killed slots 1,2 do not consume write ports.
    win(4'b1111, 4'b0110, 4'b1111, 4'b0000);
    rob.empty = 1'b0;
    #2;
    check("t2_count", {30'd0, rob.consume_count}, 32'd3);
    tick();
    check("t2_we", {30'd0, rf_we}, 32'd3);
    check("t2_waddr0", {27'd0, rf_waddr[0]}, 32'd1);
    check("t2_waddr1", {27'd0, rf_waddr[1]}, 32'd4);
    check("t2_wdata1", rf_wdata[1], 32'hC0DE_0003);
    check("t2_retired", retired_count, 32'd4);

    // Hole at slot 1: only slot 0 retires.
    win(4'b1101, 4'b0000, 4'b1111, 4'b0000);
    #2;
    check("t3_consume", {31'd0, rob.consume}, 32'd1);
    check("t3_count", {30'd0, rob.consume_count}, 32'd0);
    tick();
    check("t3_we", {30'd0, rf_we}, 32'd1);
    check("t3_waddr0", {27'd0, rf_waddr[0]}, 32'd1);
    check("t3_retired", retired_count, 32'd5);

    // Store at slot 2 ends the group after slots 0 and 1.
    win(4'b1111, 4'b0000, 4'b0101, 4'b0100);
    #2;
    check("t3b_count", {30'd0, rob.consume_count}, 32'd1);
    tick();
    check("t3b_we", {30'd0, rf_we}, 32'd1);
    check("t3b_retired", retired_count, 32'd7);

    // Store at head, ack after three waiting cycles.
    win(4'b1111, 4'b0000, 4'b0001, 4'b0001);
    #2;
    check("st_consume_run", {31'd0, rob.consume}, 32'd0);
    tick();
    check("st_req_c1", {31'd0, st_commit_req}, 32'd1);
    check("st_consume_c1", {31'd0, rob.consume}, 32'd0);
    tick();
    check("st_req_c2", {31'd0, st_commit_req}, 32'd1);
    check("st_we_c2", {30'd0, rf_we}, 32'd0);
    tick();
    check("st_req_c3", {31'd0, st_commit_req}, 32'd1);
    check("st_consume_c3", {31'd0, rob.consume}, 32'd0);
    tick();
    st_commit_ack = 1'b1;
    #2;
    check("st_req_c4", {31'd0, st_commit_req}, 32'd1);
    check("st_consume_ack", {31'd0, rob.consume}, 32'd1);
    check("st_count_ack", {30'd0, rob.consume_count}, 32'd0);
    tick();
    st_commit_ack = 1'b0;
    rob.empty = 1'b1;
    check("st_req_done", {31'd0, st_commit_req}, 32'd0);
    check("st_we_done", {30'd0, rf_we}, 32'd0);
    check("st_retired", retired_count, 32'd8);
    check("st_halted", {31'd0, halted}, 32'd0);

    // Killed store at head retires like any killed slot.
    win(4'b1111, 4'b0001, 4'b1110, 4'b0001);
    rob.empty = 1'b0;
    #2;
    check("ks_count", {30'd0, rob.consume_count}, 32'd2);
    tick();
    check("ks_req", {31'd0, st_commit_req}, 32'd0);
    check("ks_we", {30'd0, rf_we}, 32'd3);
    check("ks_waddr0", {27'd0, rf_waddr[0]}, 32'd2);
    check("ks_waddr1", {27'd0, rf_waddr[1]}, 32'd3);
    check("ks_retired", retired_count, 32'd10);

    // Halt during RUN with a full window.
    win(4'b1111, 4'b0000, 4'b1111, 4'b0000);
    halt_req = 1'b1;
    #2;
    check("h_consume_req", {31'd0, rob.consume}, 32'd0);
    tick();
    check("h_halted", {31'd0, halted}, 32'd1);
    check("h_we", {30'd0, rf_we}, 32'd0);
    #2;
    check("h_consume1", {31'd0, rob.consume}, 32'd0);
    tick();
    check("h_consume2", {31'd0, rob.consume}, 32'd0);
    check("h_retired", retired_count, 32'd10);
    halt_req = 1'b0;
    #2;
    check("h_consume_rel", {31'd0, rob.consume}, 32'd0);
    tick();
    check("h_unhalted", {31'd0, halted}, 32'd0);
    #2;
    check("h_resume_consume", {31'd0, rob.consume}, 32'd1);
    check("h_resume_count", {30'd0, rob.consume_count}, 32'd1);
    tick();
    check("h_resume_retired", retired_count, 32'd12);

    // Ack and halt together: store completes, then HALT.
    win(4'b1111, 4'b0000, 4'b0000, 4'b0001);
    tick();
    check("ah_req", {31'd0, st_commit_req}, 32'd1);
    st_commit_ack = 1'b1;
    halt_req = 1'b1;
    #2;
    check("ah_consume", {31'd0, rob.consume}, 32'd1);
    tick();
    st_commit_ack = 1'b0;
    check("ah_req_done", {31'd0, st_commit_req}, 32'd0);
    check("ah_halted", {31'd0, halted}, 32'd1);
    check("ah_retired", retired_count, 32'd13);
    halt_req = 1'b0;
    rob.empty = 1'b1;
    tick();
    check("ah_unhalted", {31'd0, halted}, 32'd0);

    // Reset in the middle of a store handshake.
    rob.empty = 1'b0;
    tick();
    check("rw_req", {31'd0, st_commit_req}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rw_req_drop", {31'd0, st_commit_req}, 32'd0);
    check("rw_consume", {31'd0, rob.consume}, 32'd0);
    check("rw_retired", retired_count, 32'd0);
    check("rw_halted", {31'd0, halted}, 32'd0);
    #1;
    reset = 1'b0;
    rob.empty = 1'b1;
    tick();
    check("rw_req_after", {31'd0, st_commit_req}, 32'd0);
    check("rw_retired_after", retired_count, 32'd0);
    win(4'b1111, 4'b0000, 4'b1111, 4'b0000);
    rob.empty = 1'b0;
    #2;
    check("rw_run_consume", {31'd0, rob.consume}, 32'd1);
    tick();
    check("rw_run_retired", retired_count, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
